// File: rtl/accum_dump_scheduler.sv
// Round-robin readout of per-channel accumulation dumps as a 6-word stream per channel.
// Latency: first word 3 cycles after a dump on an idle block; 6 words per readout; 2 bubbles between channels.
// Backpressure: words hold stable while out_valid && !out_ready; stalls are unbounded and never drop data.
module accum_dump_scheduler #(
    parameter int NUM_CHAN = 12,
    parameter int ACC_W    = 16,
    parameter int CH_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CHAN-1:0]        dump,
    input  logic [NUM_CHAN*6*ACC_W-1:0] accum,
    output logic [ACC_W-1:0]           out_data,
    output logic [CH_W-1:0]            out_chan,
    output logic [2:0]                 out_idx,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CHAN-1:0]        pending,
    output logic [NUM_CHAN-1:0]        overrun,
    input  logic [NUM_CHAN-1:0]        overrun_clr,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [CH_W-1:0]         ptr;
    logic [CH_W-1:0]         grant;
    logic [CH_W-1:0]         sel;
    logic                    sel_vld;
    logic [NUM_CHAN-1:0]     pending_q;
    logic [NUM_CHAN-1:0]     overrun_q;
    logic [NUM_CHAN-1:0]     cap_hit;
    logic [2:0]              idx_q;
    logic [6*ACC_W-1:0]      hold;
    logic                    capture;
    logic                    xfer;
    logic                    last_word;

    assign pending = pending_q;
    assign overrun = overrun_q;
    assign capture = (state == CAPTURE);

    // Round-robin search: first pending channel at or above the pointer, wrapping.
    always_comb begin
        int j;
        j       = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CHAN) begin
                j = j - NUM_CHAN;
            end
            if (!sel_vld && pending_q[j]) begin
                sel_vld = 1'b1;
                sel     = CH_W'(j);
            end
        end
    end

    // One-hot of the channel whose data is being snapshotted this cycle.
    always_comb begin
        cap_hit = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            cap_hit[c] = capture && (int'(grant) == c);
        end
    end

    // Next state and stream outputs; data/chan are forced to zero outside SEND.
    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        out_data  = '0;
        out_chan  = '0;
        out_idx   = idx_q;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        last_word = (idx_q == 3'd5);
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nx = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = hold[int'(idx_q)*ACC_W +: ACC_W];
                out_chan  = grant;
                out_last  = last_word;
                xfer      = out_ready;
                if (out_ready && last_word) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant, snapshot, pointer and word index bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            ptr   <= '0;
            idx_q <= '0;
            hold  <= '0;
        end else begin
            if (state == IDLE && sel_vld) begin
                grant <= sel;
            end
            if (capture) begin
                hold  <= accum[int'(grant)*6*ACC_W +: 6*ACC_W];
                ptr   <= (grant == CH_W'(NUM_CHAN-1)) ? '0 : grant + 1'b1;
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= last_word ? 3'd0 : idx_q + 3'd1;
            end
        end
    end

    // Request and overrun flags. A dump landing on its own capture cycle is a fresh
    // request, not an overrun, because the older data is being taken that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= (pending_q & ~cap_hit) | dump;
            overrun_q <= (overrun_q & ~overrun_clr) | (dump & pending_q & ~cap_hit);
        end
    end

endmodule

// File: tb/tb_accum_dump_scheduler.sv
// Directed bench for accum_dump_scheduler with a queue-based scoreboard.
// Stimulus pushes expected words; a negedge monitor pops and compares each transfer.
// Flag and timing checks are made directly by the stimulus process.
module tb_accum_dump_scheduler;

    localparam int NUM_CHAN = 12;
    localparam int ACC_W    = 16;
    localparam int CH_W     = 5;

    typedef struct {
        logic [CH_W-1:0]  chan;
        logic [2:0]       idx;
        logic [ACC_W-1:0] data;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_CHAN-1:0]         dump;
    logic [NUM_CHAN*6*ACC_W-1:0] accum;
    logic [ACC_W-1:0]            out_data;
    logic [CH_W-1:0]             out_chan;
    logic [2:0]                  out_idx;
    logic                        out_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_CHAN-1:0]         pending;
    logic [NUM_CHAN-1:0]         overrun;
    logic [NUM_CHAN-1:0]         overrun_clr;
    logic                        busy;

    logic [ACC_W-1:0] acc_mem [NUM_CHAN][6];
    exp_t             expq[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    accum_dump_scheduler #(.NUM_CHAN(NUM_CHAN), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst(rst), .dump(dump), .accum(accum),
        .out_data(out_data), .out_chan(out_chan), .out_idx(out_idx),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .pending(pending), .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        accum = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            for (int w = 0; w < 6; w++) begin
                accum[(c*6+w)*ACC_W +: ACC_W] = acc_mem[c][w];
            end
        end
    end

    // Monitor: every transfer must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got chan=%0d idx=%0d data=%h, expected no word",
                         out_chan, out_idx, out_data);
            end else begin
                e = expq.pop_front();
                if (out_chan !== e.chan || out_idx !== e.idx || out_data !== e.data ||
                    out_last !== (e.idx == 3'd5)) begin
                    n_fail++;
                    $display("FAIL word: got chan=%0d idx=%0d data=%h last=%b, expected chan=%0d idx=%0d data=%h last=%b",
                             out_chan, out_idx, out_data, out_last, e.chan, e.idx, e.data, (e.idx == 3'd5));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int c, input logic [ACC_W-1:0] base);
        for (int w = 0; w < 6; w++) begin
            acc_mem[c][w] = base + ACC_W'(16'h0101 * (w + 1));
        end
    endtask

    task automatic push_chan(input int c, input int nwords);
        exp_t e;
        for (int w = 0; w < nwords; w++) begin
            e.chan = CH_W'(c);
            e.idx  = 3'(w);
            e.data = acc_mem[c][w];
            expq.push_back(e);
        end
    endtask

    task automatic pulse(input logic [NUM_CHAN-1:0] m);
        dump = m;
        tick();
        dump = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(expq.size() != 0 || busy), 32'd0);
        expq.delete();
    endtask

    task automatic wait_word(input string name, input logic [2:0] idx);
        int n;
        n = 0;
        while (!(out_valid && out_idx == idx) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_reached"}, 32'(out_valid && out_idx == idx), 32'd1);
    endtask

    initial begin
        rst = 1'b1; dump = '0; out_ready = 1'b0; overrun_clr = '0;
        for (int c = 0; c < NUM_CHAN; c++) set_chan(c, ACC_W'(c << 12));
        set_chan(3, 16'h0000);
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_pending", 32'(pending),   32'd0);
        chk("rst_overrun", 32'(overrun),   32'd0);
        chk("rst_data",    32'(out_data),  32'd0);
        chk("rst_chan_idx_last", {out_chan, out_idx, out_last}, 32'd0);

        // Single channel 3, latency and pending lifetime.
        out_ready = 1'b1;
        push_chan(3, 6);
        pulse(12'(1 << 3));
        chk("t1_pend_set",   32'(pending[3]), 32'd1);
        chk("t1_valid_c1",   32'(out_valid),  32'd0);
        tick();
        chk("t1_capture_busy", 32'(busy),     32'd1);
        chk("t1_pend_at_cap",  32'(pending[3]), 32'd1);
        chk("t1_valid_c2",   32'(out_valid),  32'd0);
        tick();
        chk("t1_valid_c3",   32'(out_valid),  32'd1);
        chk("t1_pend_clr",   32'(pending[3]), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("t1_last_word",  32'(out_last && out_valid), 32'd1);
        tick();
        chk("t1_done_6cyc",  32'(out_valid), 32'd0);
        wait_drain("t1");

        // Move pointer to 6 via channel 5, then simultaneous 1/5/9 -> 9,1,5.
        push_chan(5, 6);
        pulse(12'(1 << 5));
        wait_drain("t2a");
        push_chan(9, 6); push_chan(1, 6); push_chan(5, 6);
        pulse(12'((1 << 1) | (1 << 5) | (1 << 9)));
        wait_drain("t2b");
        // Pointer is now 6: channels 4 and 6 together must serve 6 first.
        push_chan(6, 6); push_chan(4, 6);
        pulse(12'((1 << 4) | (1 << 6)));
        wait_drain("t2c");

        // Backpressure at word 2 of channel 7.
        push_chan(7, 6);
        pulse(12'(1 << 7));
        wait_word("t3", 3'd2);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (!(out_valid && out_idx == 3'd2 && out_chan == 5'd7 && out_data == acc_mem[7][2])) begin
                n_fail++;
                $display("FAIL t3_hold: got v=%b idx=%0d chan=%0d data=%h, expected v=1 idx=2 chan=7 data=%h",
                         out_valid, out_idx, out_chan, out_data, acc_mem[7][2]);
            end
        end
        out_ready = 1'b1;
        wait_drain("t3");

        // Overrun on channel 4 while channel 0 stalls.
        out_ready = 1'b0;
        push_chan(0, 6);
        pulse(12'(1 << 0));
        wait_word("t4", 3'd0);
        pulse(12'(1 << 4));
        for (int k = 0; k < 4; k++) tick();
        chk("t4_no_ovr_yet", 32'(overrun[4]), 32'd0);
        set_chan(4, 16'hA000);
        pulse(12'(1 << 4));
        chk("t4_overrun", 32'(overrun[4]), 32'd1);
        chk("t4_pending", 32'(pending[4]), 32'd1);
        push_chan(4, 6);
        out_ready = 1'b1;
        wait_drain("t4");
        chk("t4_pend_clr",  32'(pending[4]), 32'd0);
        chk("t4_ovr_stick", 32'(overrun),    32'(1 << 4));
        overrun_clr = 12'(1 << 4);
        tick();
        overrun_clr = '0;
        chk("t4_ovr_clr", 32'(overrun[4]), 32'd0);
        // Set and clear in the same cycle: set wins.
        push_chan(4, 6);
        pulse(12'(1 << 4));
        overrun_clr = 12'(1 << 4);
        pulse(12'(1 << 4));
        overrun_clr = '0;
        chk("t4_set_wins", 32'(overrun[4]), 32'd1);
        wait_drain("t4b");
        overrun_clr = 12'(1 << 4);
        tick();
        overrun_clr = '0;

        // Dump on channel 2 during its own CAPTURE cycle.
        push_chan(2, 6);
        pulse(12'(1 << 2));
        tick();
        chk("t5_in_capture", 32'(busy && !out_valid), 32'd1);
        dump = 12'(1 << 2);
        tick();
        dump = '0;
        set_chan(2, 16'h5000);
        chk("t5_pending", 32'(pending[2]), 32'd1);
        chk("t5_no_ovr",  32'(overrun[2]), 32'd0);
        push_chan(2, 6);
        wait_drain("t5");

        // Reset mid-SEND at word 3 of channel 8.
        push_chan(8, 3);
        pulse(12'(1 << 8));
        wait_word("t6", 3'd3);
        out_ready = 1'b0;
        pulse(12'(1 << 10));
        pulse(12'(1 << 10));
        chk("t6_ovr_pre", 32'(overrun[10]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid",   32'(out_valid), 32'd0);
        chk("t6_flags",   {pending, overrun}, 32'd0);
        chk("t6_idle",    32'(busy),      32'd0);
        chk("t6_q_empty", 32'(expq.size()), 32'd0);
        out_ready = 1'b1;
        push_chan(1, 6); push_chan(11, 6);
        pulse(12'((1 << 1) | (1 << 11)));
        wait_drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_dump_scheduler.md
Name: accum_dump_scheduler

Overview:
- Collects the dump events from NUM_CHAN tracking channels and arbitrates between them round-robin.
- For each granted channel, snapshots its six accumulations (IE, QE, IP, QP, IL, QL) and streams them as words over a valid/ready interface to the bus-side readout buffer.
- Flags channels whose previous dump was not read out before the next dump arrived (overrun).
- Sits between the channel array and the CPU interface / status register block.

Parameters:
- NUM_CHAN, 12, number of tracking channels served (2..32).
- ACC_W, 16, width of each accumulation word.
- CH_W, 5, width of channel index output; must satisfy 2**CH_W >= NUM_CHAN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- dump  in  NUM_CHAN  per-channel dump pulse, one cycle wide; accumulations are valid from the cycle after the pulse until the next pulse.
- accum  in  NUM_CHAN*6*ACC_W  flattened accumulations. Channel c occupies bits [c*6*ACC_W +: 6*ACC_W]. Word order within a channel, low to high: IE, QE, IP, QP, IL, QL.
- out_data  out  ACC_W  current word.
- out_chan  out  CH_W  channel index of the current word.
- out_idx  out  3  word index 0..5 (IE..QL).
- out_last  out  1  high with out_idx==5.
- out_valid  out  1  word presented.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- pending  out  NUM_CHAN  per-channel dump-awaiting-readout flags.
- overrun  out  NUM_CHAN  sticky per-channel overrun flags.
- overrun_clr  in  NUM_CHAN  write-one-to-clear strobe for overrun.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - pending = 0, overrun = 0, out_valid = 0, out_data = 0, out_chan = 0, out_idx = 0, out_last = 0, busy = 0.
  - Round-robin pointer = 0; FSM = IDLE.
  - Reset mid-stream abandons the transfer; no further words are emitted.
- pending[c]:
  - Set on the cycle after dump[c].
  - Cleared in the CAPTURE cycle for channel c.
  - If dump[c] coincides with that CAPTURE cycle, pending[c] stays set and overrun[c] is not set (the old data was captured; the new data is a fresh request).
- overrun[c]:
  - Set when dump[c]=1, pending[c]=1, and channel c is not being captured that cycle.
  - Cleared by overrun_clr[c]=1. If set and clear coincide, set wins.
  - pending is unaffected by overrun; the channel is read out once, with the newest data.
- FSM states: IDLE, CAPTURE, SEND.
  - IDLE: if any pending bit is set, select the first set bit searching upward from the pointer, wrapping modulo NUM_CHAN. Register the grant index; go to CAPTURE.
  - CAPTURE (1 cycle):
    - Copy the granted channel's 6*ACC_W bits into the holding register.
    - Clear pending[grant].
    - Pointer = grant+1, wrapping NUM_CHAN-1 to 0.
    - out_idx = 0; go to SEND.
  - SEND:
    - out_valid=1; out_data = holding word out_idx; out_chan = grant; out_last = (out_idx==5).
    - On each transfer, out_idx increments.
    - On a transfer with out_last, drop out_valid and return to IDLE.
    - Outputs hold stable while out_valid && !out_ready. Backpressure is unbounded.
- Latency:
  - A dump on an idle scheduler produces the first out_valid 3 cycles later (pending set, IDLE grant, CAPTURE).
  - A full readout takes 6 cycles at out_ready=1.
  - Back-to-back channels: SEND-last, IDLE, CAPTURE, SEND, so there are 2 bubble cycles.
- The snapshot isolates the stream from dumps arriving during SEND; a new dump on the channel being sent only sets pending.
- Multiple simultaneous dumps are served one per readout, in round-robin order.

Test Plan:
- Single channel: dump[3] with out_ready=1 and accum words 0x0101..0x0606 → out_valid 3 cycles later; 6 words 0x0101..0x0606; out_chan=3; out_idx 0..5; out_last on word 5; pending[3] clears at CAPTURE.
- Simultaneous dump[1], dump[5], dump[9] with pointer=6 → service order 9, 1, 5; pointer ends at 6.
- Backpressure: out_ready low for 10 cycles at out_idx=2 → out_data, out_idx and out_chan held constant; the stream resumes at word 2; no word is dropped or duplicated.
- Overrun: two dump[4] pulses 5 cycles apart while out_ready=0 and channel 0 is streaming → overrun[4]=1, pending[4]=1, one readout of channel 4; overrun_clr[4] then clears it. Set/clear in the same cycle → stays 1.
- Dump during capture: dump[2] in the CAPTURE cycle of channel 2 → old snapshot streamed, pending[2] remains 1, overrun[2]=0, channel 2 read out again afterwards.
- Reset mid-SEND at out_idx=3 → the next cycle has out_valid=0 and pending/overrun all 0; FSM in IDLE; the next dump is served normally from pointer 0.
